// File: rtl/video_layer_mixer_pkg.sv
// Shared definitions for the video layer mixer: register map, reset values,
// priority encodings and the layer selection function.
package video_layer_mixer_pkg;

   localparam logic [2:0] REG_ENABLE   = 3'd0;
   localparam logic [2:0] REG_PRIORITY = 3'd1;
   localparam logic [2:0] REG_BG_R     = 3'd2;
   localparam logic [2:0] REG_BG_G     = 3'd3;
   localparam logic [2:0] REG_BG_B     = 3'd4;

   localparam logic [2:0] ENABLE_RST = 3'b111;
   localparam logic [7:0] BG_RST     = 8'h00;

   typedef enum logic {
      PRI_SPRITE_FIRST = 1'b0,
      PRI_CHAR_FIRST   = 1'b1
   } pri_mode_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef struct packed {
      logic      a;
      rgb_t      c;
   } pix_t;

   typedef struct packed {
      logic [2:0] en;
      pri_mode_t  pri;
      rgb_t       bg;
   } ctrl_t;

   localparam ctrl_t CTRL_RST = '{
      en:  ENABLE_RST,
      pri: PRI_SPRITE_FIRST,
      bg:  '{r: BG_RST, g: BG_RST, b: BG_RST}
   };

   // Highest-priority enabled opaque layer wins; background when none qualifies.
   function automatic rgb_t layer_select(input ctrl_t ctl, input pix_t tile,
                                         input pix_t chr, input pix_t spr);
      logic w_t;
      logic w_c;
      logic w_s;
      rgb_t w_out;
      w_t = ctl.en[0] & tile.a;
      w_c = ctl.en[1] & chr.a;
      w_s = ctl.en[2] & spr.a;
      if (ctl.pri == PRI_CHAR_FIRST) begin
         if (w_c)      w_out = chr.c;
         else if (w_s) w_out = spr.c;
         else if (w_t) w_out = tile.c;
         else          w_out = ctl.bg;
      end else begin
         if (w_s)      w_out = spr.c;
         else if (w_c) w_out = chr.c;
         else if (w_t) w_out = tile.c;
         else          w_out = ctl.bg;
      end
      return w_out;
   endfunction

endpackage

// File: rtl/video_layer_mixer_pixel_delay_line.sv
// Pixel-enable gated shift register of DEPTH stages and W bits; DEPTH 0 is a
// straight wire.
module pixel_delay_line #(
   parameter int DEPTH = 0,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_ce,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic w_unused;
         assign w_unused = &{1'b0, clk, reset, i_ce};
         assign o_q      = i_d;
      end else begin : g_shift
         logic [DEPTH-1:0][W-1:0] r_taps;

         // Shift one stage per pixel enable; cleared by reset.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_taps <= '0;
            end else if (i_ce) begin
               r_taps[0] <= i_d;
               for (int i = 1; i < DEPTH; i++) begin
                  r_taps[i] <= r_taps[i-1];
               end
            end
         end

         assign o_q = r_taps[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/video_layer_mixer.sv
// Composites tilemap, character and sprite layers over a background colour,
// with CPU control registers shadowed at vblank start.
module video_layer_mixer
   import video_layer_mixer_pkg::*;
#(
   parameter int TILEMAP_DELAY = 0,
   parameter int SYNC_DELAY    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce_pix,
   input  logic       hblank,
   input  logic       vblank,
   input  logic       hsync,
   input  logic       vsync,
   input  logic [7:0] tilemap_r,
   input  logic [7:0] tilemap_g,
   input  logic [7:0] tilemap_b,
   input  logic       tilemap_a,
   input  logic [7:0] char_r,
   input  logic [7:0] char_g,
   input  logic [7:0] char_b,
   input  logic       char_a,
   input  logic [7:0] sprite_r,
   input  logic [7:0] sprite_g,
   input  logic [7:0] sprite_b,
   input  logic       sprite_a,
   input  logic [2:0] addr,
   input  logic [7:0] data_in,
   input  logic       write,
   output logic [7:0] data_out,
   output logic [7:0] rgb_r,
   output logic [7:0] rgb_g,
   output logic [7:0] rgb_b,
   output logic       out_hblank,
   output logic       out_vblank,
   output logic       out_hsync,
   output logic       out_vsync
);

   ctrl_t r_cpu;
   ctrl_t r_shadow;
   ctrl_t w_cpu_nxt;
   logic  r_vblank_d;
   logic  w_vb_rise;

   pix_t  w_tile_in;
   pix_t  w_tile_dly;
   pix_t  r_s1_tile;
   pix_t  r_s1_char;
   pix_t  r_s1_sprite;
   logic  r_s1_blank;
   rgb_t  w_sel;
   rgb_t  r_rgb;
   logic [3:0] w_sync_dly;

   assign w_vb_rise = vblank & ~r_vblank_d;

   // Next CPU register image; the shadow also loads this so a write on the
   // vblank edge lands in the new frame.
   always_comb begin
      w_cpu_nxt = r_cpu;
      if (write) begin
         case (addr)
            REG_ENABLE:   w_cpu_nxt.en   = data_in[2:0];
            REG_PRIORITY: w_cpu_nxt.pri  = pri_mode_t'(data_in[0]);
            REG_BG_R:     w_cpu_nxt.bg.r = data_in;
            REG_BG_G:     w_cpu_nxt.bg.g = data_in;
            REG_BG_B:     w_cpu_nxt.bg.b = data_in;
            default:      w_cpu_nxt      = r_cpu;
         endcase
      end else begin
         w_cpu_nxt = r_cpu;
      end
   end

   // CPU read-back always shows the CPU-side copy.
   always_comb begin
      data_out = 8'h00;
      case (addr)
         REG_ENABLE:   data_out = {5'b00000, r_cpu.en};
         REG_PRIORITY: data_out = {7'b0000000, r_cpu.pri};
         REG_BG_R:     data_out = r_cpu.bg.r;
         REG_BG_G:     data_out = r_cpu.bg.g;
         REG_BG_B:     data_out = r_cpu.bg.b;
         default:      data_out = 8'h00;
      endcase
   end

   // CPU registers, vblank edge detector and frame shadow (not ce-gated).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cpu      <= CTRL_RST;
         r_shadow   <= CTRL_RST;
         r_vblank_d <= 1'b0;
      end else begin
         r_cpu      <= w_cpu_nxt;
         r_vblank_d <= vblank;
         if (w_vb_rise) begin
            r_shadow <= w_cpu_nxt;
         end
      end
   end

   assign w_tile_in = '{a: tilemap_a, c: '{r: tilemap_r, g: tilemap_g, b: tilemap_b}};

   pixel_delay_line #(
      .DEPTH (TILEMAP_DELAY),
      .W     ($bits(pix_t))
   ) u_tile_dly (
      .clk   (clk),
      .reset (reset),
      .i_ce  (ce_pix),
      .i_d   (w_tile_in),
      .o_q   (w_tile_dly)
   );

   pixel_delay_line #(
      .DEPTH (SYNC_DELAY),
      .W     (4)
   ) u_sync_dly (
      .clk   (clk),
      .reset (reset),
      .i_ce  (ce_pix),
      .i_d   ({hblank, vblank, hsync, vsync}),
      .o_q   (w_sync_dly)
   );

   // Stage 1: capture all layers and the blanking state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_tile   <= '0;
         r_s1_char   <= '0;
         r_s1_sprite <= '0;
         r_s1_blank  <= 1'b0;
      end else if (ce_pix) begin
         r_s1_tile   <= w_tile_dly;
         r_s1_char   <= '{a: char_a, c: '{r: char_r, g: char_g, b: char_b}};
         r_s1_sprite <= '{a: sprite_a, c: '{r: sprite_r, g: sprite_g, b: sprite_b}};
         r_s1_blank  <= hblank | vblank;
      end
   end

   assign w_sel = layer_select(r_shadow, r_s1_tile, r_s1_char, r_s1_sprite);

   // Stage 2: registered colour, forced black while blanking.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rgb <= '0;
      end else if (ce_pix) begin
         r_rgb <= r_s1_blank ? rgb_t'(24'h000000) : w_sel;
      end
   end

   assign rgb_r      = r_rgb.r;
   assign rgb_g      = r_rgb.g;
   assign rgb_b      = r_rgb.b;
   assign out_hblank = w_sync_dly[3];
   assign out_vblank = w_sync_dly[2];
   assign out_hsync  = w_sync_dly[1];
   assign out_vsync  = w_sync_dly[0];

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed, table-driven bench for video_layer_mixer (tile delay 0 and 2).
module tb_video_layer_mixer;

   logic       clk = 1'b0;
   logic       reset, ce_pix, hblank, vblank, hsync, vsync;
   logic [7:0] tilemap_r, tilemap_g, tilemap_b, char_r, char_g, char_b;
   logic [7:0] sprite_r, sprite_g, sprite_b, data_in;
   logic       tilemap_a, char_a, sprite_a, write;
   logic [2:0] addr;

   logic [7:0] data_out, rgb_r, rgb_g, rgb_b;
   logic       out_hblank, out_vblank, out_hsync, out_vsync;
   logic [7:0] d2_data_out, d2_rgb_r, d2_rgb_g, d2_rgb_b;
   logic       d2_hblank, d2_vblank, d2_hsync, d2_vsync;

   int total = 0;
   int bad   = 0;

   localparam logic [23:0] T_COL = 24'h0A141E;
   localparam logic [23:0] C_COL = 24'hC0C1C2;
   localparam logic [23:0] S_COL = 24'h5A5B5C;

   always #5 clk = ~clk;

   video_layer_mixer #(.TILEMAP_DELAY(0)) dut (
      .clk(clk), .reset(reset), .ce_pix(ce_pix),
      .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
      .tilemap_r(tilemap_r), .tilemap_g(tilemap_g), .tilemap_b(tilemap_b), .tilemap_a(tilemap_a),
      .char_r(char_r), .char_g(char_g), .char_b(char_b), .char_a(char_a),
      .sprite_r(sprite_r), .sprite_g(sprite_g), .sprite_b(sprite_b), .sprite_a(sprite_a),
      .addr(addr), .data_in(data_in), .write(write), .data_out(data_out),
      .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
      .out_hblank(out_hblank), .out_vblank(out_vblank), .out_hsync(out_hsync), .out_vsync(out_vsync)
   );

   video_layer_mixer #(.TILEMAP_DELAY(2)) dut2 (
      .clk(clk), .reset(reset), .ce_pix(ce_pix),
      .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
      .tilemap_r(tilemap_r), .tilemap_g(tilemap_g), .tilemap_b(tilemap_b), .tilemap_a(tilemap_a),
      .char_r(char_r), .char_g(char_g), .char_b(char_b), .char_a(char_a),
      .sprite_r(sprite_r), .sprite_g(sprite_g), .sprite_b(sprite_b), .sprite_a(sprite_a),
      .addr(addr), .data_in(data_in), .write(write), .data_out(d2_data_out),
      .rgb_r(d2_rgb_r), .rgb_g(d2_rgb_g), .rgb_b(d2_rgb_b),
      .out_hblank(d2_hblank), .out_vblank(d2_vblank), .out_hsync(d2_hsync), .out_vsync(d2_vsync)
   );

   typedef struct {
      logic [2:0]  en;
      logic        pri;
      logic        ta, ca, sa, hb;
      logic [23:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pix();
      ce_pix = 1'b1;
      @(posedge clk); #1;
      ce_pix = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      addr = a; data_in = d; write = 1'b1;
      @(posedge clk); #1;
      write = 1'b0;
   endtask

   task automatic vb_pulse();
      vblank = 1'b1;
      @(posedge clk); #1;
      vblank = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic layers(input logic ta, input logic ca, input logic sa);
      {tilemap_r, tilemap_g, tilemap_b} = T_COL; tilemap_a = ta;
      {char_r, char_g, char_b}          = C_COL; char_a    = ca;
      {sprite_r, sprite_g, sprite_b}    = S_COL; sprite_a  = sa;
   endtask

   function automatic logic [31:0] rgb1();
      return {8'h00, rgb_r, rgb_g, rgb_b};
   endfunction

   function automatic logic [31:0] rgb2();
      return {8'h00, d2_rgb_r, d2_rgb_g, d2_rgb_b};
   endfunction

   vec_t       vecs [12];
   logic [7:0] hist [10];

   initial begin
      vecs[0]  = '{3'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, S_COL};
      vecs[1]  = '{3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, C_COL};
      vecs[2]  = '{3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_COL};
      vecs[3]  = '{3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, S_COL};
      vecs[4]  = '{3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, T_COL};
      vecs[5]  = '{3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h010203};
      vecs[6]  = '{3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_COL};
      vecs[7]  = '{3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, S_COL};
      vecs[8]  = '{3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h010203};
      vecs[9]  = '{3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h010203};
      vecs[10] = '{3'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000000};
      vecs[11] = '{3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, S_COL};

      reset = 1'b1; ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b0;
      hsync = 1'b0; vsync = 1'b0; addr = 3'd0; data_in = 8'h00; write = 1'b0;
      layers(1'b0, 1'b0, 1'b0);
      idle(2);

      // Reset state
      chk("rst_rgb", rgb1(), 32'h0);
      chk("rst_sync", {28'h0, out_hblank, out_vblank, out_hsync, out_vsync}, 32'h0);
      chk("rst_reg0", {24'h0, data_out}, 32'h07);

      // Pipeline refill: tile only, two pixel enables
      reset = 1'b0; hsync = 1'b1;
      layers(1'b1, 1'b0, 1'b0);
      pix();
      chk("fill_1pix_rgb", rgb1(), 32'h0);
      chk("fill_1pix_hsync", {31'h0, out_hsync}, 32'h0);
      pix();
      chk("fill_2pix_rgb", rgb1(), {8'h00, T_COL});
      chk("fill_2pix_hsync", {31'h0, out_hsync}, 32'h1);
      hsync = 1'b0;

      // Priority change takes effect only after vblank edge
      layers(1'b1, 1'b1, 1'b1);
      pix(); pix();
      chk("pri0_sprite", rgb1(), {8'h00, S_COL});
      wr(3'd1, 8'h01);
      chk("pri_readback", {24'h0, data_out}, 32'h01);
      pix(); pix();
      chk("pri_pre_vblank", rgb1(), {8'h00, S_COL});
      vb_pulse();
      pix(); pix();
      chk("pri1_char", rgb1(), {8'h00, C_COL});

      // All layers disabled -> background; hblank forces black
      wr(3'd0, 8'h00); wr(3'd2, 8'h11); wr(3'd3, 8'h22); wr(3'd4, 8'h33);
      vb_pulse();
      pix(); pix();
      chk("bg_active", rgb1(), 32'h00112233);
      hblank = 1'b1;
      pix(); pix();
      chk("bg_hblank_rgb", rgb1(), 32'h0);
      chk("bg_hblank_out", {31'h0, out_hblank}, 32'h1);
      hblank = 1'b0;

      // Write in the same clock as the vblank rising edge
      vblank = 1'b1; addr = 3'd2; data_in = 8'h55; write = 1'b1;
      @(posedge clk); #1;
      write = 1'b0; vblank = 1'b0;
      @(posedge clk); #1;
      pix(); pix();
      chk("vb_edge_write", rgb1(), 32'h00552233);

      // Table of layer/enable/priority combinations
      wr(3'd2, 8'h01); wr(3'd3, 8'h02); wr(3'd4, 8'h03);
      for (int i = 0; i < 12; i++) begin
         wr(3'd0, {5'b00000, vecs[i].en});
         wr(3'd1, {7'b0000000, vecs[i].pri});
         vb_pulse();
         layers(vecs[i].ta, vecs[i].ca, vecs[i].sa);
         hblank = vecs[i].hb;
         pix(); pix();
         chk($sformatf("vec%0d_rgb", i), rgb1(), {8'h00, vecs[i].exp});
         chk($sformatf("vec%0d_hblank", i), {31'h0, out_hblank}, {31'h0, vecs[i].hb});
         hblank = 1'b0;
      end

      // Tilemap delay alignment with 3-clock enable gaps
      wr(3'd0, 8'h07); wr(3'd1, 8'h00);
      vb_pulse();
      layers(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         hist[k] = 8'h40 + 8'(k);
         tilemap_r = hist[k];
         pix();
         if (k >= 1) chk($sformatf("tdly0_k%0d", k), rgb1(), {8'h00, hist[k-1], 8'h14, 8'h1E});
         if (k >= 3) chk($sformatf("tdly2_k%0d", k), rgb2(), {8'h00, hist[k-3], 8'h14, 8'h1E});
         idle(3);
         if (k >= 3) chk($sformatf("tdly2_hold_k%0d", k), rgb2(), {8'h00, hist[k-3], 8'h14, 8'h1E});
      end
      char_a = 1'b1;
      for (int k = 0; k < 6; k++) begin
         hist[k] = 8'h80 + 8'(k);
         char_r = hist[k];
         pix();
         if (k >= 1) chk($sformatf("cdly2_k%0d", k), rgb2(), {8'h00, hist[k-1], 8'hC1, 8'hC2});
         idle(3);
      end

      // Reset mid-line with non-default registers
      wr(3'd0, 8'h05); wr(3'd1, 8'h01); wr(3'd3, 8'h77);
      vb_pulse();
      layers(1'b1, 1'b1, 1'b1);
      pix(); pix();
      chk("pre_rst_sprite", rgb1(), {8'h00, S_COL});
      reset = 1'b1; ce_pix = 1'b1; addr = 3'd0;
      @(posedge clk); #1;
      ce_pix = 1'b0;
      chk("mid_rst_reg0", {24'h0, data_out}, 32'h07);
      chk("mid_rst_rgb", rgb1(), 32'h0);
      addr = 3'd1;
      #1 chk("mid_rst_reg1", {24'h0, data_out}, 32'h0);
      addr = 3'd3;
      #1 chk("mid_rst_reg3", {24'h0, data_out}, 32'h0);
      reset = 1'b0;
      pix(); pix();
      chk("post_rst_shadow_pri", rgb1(), {8'h00, S_COL});
      layers(1'b0, 1'b0, 1'b0);
      pix(); pix();
      chk("post_rst_shadow_bg", rgb1(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_layer_mixer.md
Name: video_layer_mixer

Overview:
Downstream of the tilemap stage. Composites the tilemap RGBA pixel with the character-map and sprite layers and a programmable background colour into the final RGB stream for the video output. Sync and blank signals are delayed to match. Control registers are CPU-visible and are shadowed at vblank start, so layer changes never tear mid-frame.

Parameters:
TILEMAP_DELAY, 0, extra pixel delays (0..3) applied to the tilemap path to align it with the char/sprite layers
SYNC_DELAY, 2, pixel-enable latency from layer inputs to rgb_out; fixed by the pipeline, exposed for reference only

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
ce_pix  in  1  pixel enable, one clk pulse per pixel
hblank  in  1  horizontal blank
vblank  in  1  vertical blank
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
tilemap_r/g/b  in  8 each  tilemap colour
tilemap_a  in  1  tilemap opaque flag
char_r/g/b  in  8 each  character-map colour
char_a  in  1  char opaque flag
sprite_r/g/b  in  8 each  sprite colour
sprite_a  in  1  sprite opaque flag
addr  in  3  control register index
data_in  in  8  CPU write data
write  in  1  CPU write strobe, one clk
data_out  out  8  CPU read-back of register[addr], combinational
rgb_r/g/b  out  8 each  final colour
out_hblank/out_vblank/out_hsync/out_vsync  out  1 each  delayed sync/blank

Behaviour:
- Registers, with reset values:
  - 0 = layer enable: bit0 tile, bit1 char, bit2 sprite; reset 8'h07.
  - 1 = priority mode: bit0 0 = sprite>char>tile, 1 = char>sprite>tile; reset 0.
  - 2/3/4 = background R/G/B; reset 0.
  - 5-7 read 0; writes ignored.
- data_out reflects the CPU-side register, not the shadow.
- Shadow: active copies of regs 0-4 load on the vblank rising edge, detected on clk without regard to ce_pix. A write in the same clk as that edge is forwarded into the shadow.
- On reset, CPU registers and shadows load their reset values immediately.
- Reset state: rgb_* = 0 and out_* sync/blank = 0 until the pipeline refills, which takes 2 ce_pix.
- Pipeline advances only when ce_pix = 1; all state holds otherwise.
  - Stage 1 registers all layer inputs and sync/blank. The tilemap path passes through TILEMAP_DELAY extra ce_pix-gated registers first; TILEMAP_DELAY = 0 means no extra registers.
  - Stage 2 selects and registers rgb_* and out_*.
- Select rule, per the shadow state: a layer is a candidate if its enable bit = 1 and its _a = 1. Output the highest-priority candidate; if none, output the background colour.
- Blanking: if stage-1 hblank or vblank = 1, rgb_* = 0 regardless of layers.
- No arithmetic blending; pure selection. The 8-bit widths pass through unchanged.
- A pixel presented with ce_pix at edge N appears on rgb_* after edge N+1 (2 ce_pix latency); the tilemap pixel takes 2 + TILEMAP_DELAY.
- Enable mask 0 gives background during active video; background is also used when all candidates are transparent.
- ce_pix held low: outputs frozen.

Decomposition:
- Shared package: register index constants, reset values, priority mode encodings.
- One sub-module, pixel_delay_line: a parameterised ce-gated shift register of depth N and width W, used for the tilemap alignment. Depth 0 is a pass-through.

Test Plan:
- Reset, then drive tile a=1 rgb=10/20/30 and char/sprite a=0 with blanks low → after 2 ce_pix, rgb = 10/20/30; before that, 0.
- All three layers opaque with distinct colours, mode 0 → sprite colour. Write reg1 = 1, then pulse vblank → char colour from the next frame. Before the vblank edge, still sprite; data_out reads 1 immediately.
- Write reg0 = 0, bg = 0x11/0x22/0x33, then vblank edge → active video shows 11/22/33; during hblank, rgb = 0.
- Write reg2 = 0x55 in the same clk as the vblank rising edge → next frame background R = 0x55.
- TILEMAP_DELAY = 2, tile pattern changing every pixel → tile pixel appears 4 ce_pix after input. Char path latency stays at 2; ce_pix gaps of 3 clk don't alter alignment.
- Assert reset mid-line with non-default registers → next clk data_out for reg0 = 0x07, rgb = 0, and shadows are at defaults.
